// File: rtl/core7_oci_trace_capture.sv
// Debug trace capture buffer: stores qualified {count, word} trace entries in a
// circular FIFO during a capture session and lets the host drain them afterwards.
module core7_oci_trace_capture #(
  parameter int DATA_W    = 30,
  parameter int CNT_W     = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic                       dct_valid,
  input  logic [DATA_W-1:0]          dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_req,
  output logic [CNT_W+DATA_W-1:0]    rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [7:0]                 overflow_cnt,
  output logic [1:0]                 state,
  output logic                       done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CNT_W + DATA_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        st;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic full;
  logic wr_en;
  logic rd_en;
  logic do_store;
  logic adv_rd;
  logic lost;

  always_comb begin
    full   = (fill_level == FULL_LVL);
    wr_en  = (st == CAPTURE) && dct_valid && (dct_count != '0);
    rd_en  = rd_req && (fill_level != '0) && (st != IDLE);
    // A full buffer still accepts a word when a pop frees a slot, or in wrap
    // mode where the new word takes the oldest entry's slot.
    do_store = wr_en && (!full || rd_en || (WRAP_MODE != 0));
    adv_rd   = rd_en || (wr_en && full && (WRAP_MODE != 0));
    lost     = wr_en && full && !rd_en;
    state    = st;
  end

  always_ff @(posedge clk) begin
    if (!reset && do_store) begin
      mem[wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill_level   <= '0;
      overflow_cnt <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      done         <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_ptr];
      end

      if (st == DONE && arm) begin
        st           <= CAPTURE;
        done         <= 1'b0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        fill_level   <= '0;
        overflow_cnt <= '0;
      end else begin
        case (st)
          IDLE:    if (arm) st <= CAPTURE;
          CAPTURE: if (test_ending || test_has_ended) st <= DRAIN;
          DRAIN: begin
            if (test_has_ended && fill_level == '0) begin
              st   <= DONE;
              done <= 1'b1;
            end
          end
          default: ;
        endcase

        if (do_store) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (adv_rd) begin
          rd_ptr <= rd_ptr + 1'b1;
        end

        if (wr_en && !rd_en && !full) begin
          fill_level <= fill_level + 1'b1;
        end else if (rd_en && !wr_en) begin
          fill_level <= fill_level - 1'b1;
        end

        if (lost && overflow_cnt != 8'hFF) begin
          overflow_cnt <= overflow_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_core7_oci_trace_capture.sv
// Bench for core7_oci_trace_capture: drop-mode and wrap-mode instances share
// stimulus; a queue-based reference model feeds a read-data scoreboard.
module tb_core7_oci_trace_capture;

  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int EW     = CNT_W + DATA_W;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, arm, dct_valid, test_ending, test_has_ended, rd_req;
  logic [DATA_W-1:0] dct_buffer;
  logic [CNT_W-1:0]  dct_count;

  logic [EW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic [LW-1:0] fill0, fill1;
  logic [7:0]    ovf0, ovf1;
  logic [1:0]    st0, st1;
  logic          done0, done1;

  core7_oci_trace_capture #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_req(rd_req), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .fill_level(fill0), .overflow_cnt(ovf0),
    .state(st0), .done(done0)
  );

  core7_oci_trace_capture #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .WRAP_MODE(1)
  ) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .rd_req(rd_req), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .fill_level(fill1), .overflow_cnt(ovf1),
    .state(st1), .done(done1)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: stored entries as queues, session phase 0..3.
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  logic [EW-1:0] exp0[$];
  logic [EW-1:0] exp1[$];
  int m_state = 0;
  int m_ovf   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic model_edge();
    int sz = q0.size();
    bit wr, rd;
    logic [EW-1:0] w;
    if (reset) begin
      q0.delete(); q1.delete();
      m_ovf = 0; m_state = 0;
      return;
    end
    wr = (m_state == 1) && dct_valid && (dct_count != 0);
    rd = rd_req && (sz > 0) && (m_state != 0);
    w  = {dct_count, dct_buffer};
    if (rd) begin
      exp0.push_back(q0.pop_front());
      exp1.push_back(q1.pop_front());
    end
    if (wr) begin
      if (q0.size() < DEPTH) begin
        q0.push_back(w);
        q1.push_back(w);
      end else begin
        if (m_ovf < 255) m_ovf++;
        void'(q1.pop_front());
        q1.push_back(w);
      end
    end
    case (m_state)
      0: if (arm) m_state = 1;
      1: if (test_ending || test_has_ended) m_state = 2;
      2: if (test_has_ended && sz == 0) m_state = 3;
      default: if (arm) begin
        m_state = 1; m_ovf = 0;
        q0.delete(); q1.delete();
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("fill_drop", fill0, q0.size());
    chk("fill_wrap", fill1, q1.size());
    chk("ovf_drop", ovf0, m_ovf);
    chk("ovf_wrap", ovf1, m_ovf);
    chk("state_drop", st0, m_state);
    chk("state_wrap", st1, m_state);
    chk("done_drop", done0, m_state == 3);
    chk("done_wrap", done1, m_state == 3);
  endtask

  task automatic clr();
    reset = 0; arm = 0; dct_valid = 0; dct_buffer = '0; dct_count = '0;
    test_ending = 0; test_has_ended = 0; rd_req = 0;
  endtask

  task automatic wr_word(input int cnt, input logic [DATA_W-1:0] data);
    dct_valid = 1; dct_count = CNT_W'(cnt); dct_buffer = data;
  endtask

  task automatic end_and_drain();
    clr(); test_ending = 1; step();
    clr(); test_has_ended = 1; rd_req = 1;
    for (int n = 0; n < 40 && m_state != 3; n++) step();
    clr();
  endtask

  // Scoreboard monitor: every presented read must match the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid0) begin
      if (exp0.size() == 0) chk("rd_unexpected_drop", rd_valid0, 0);
      else chk("rd_data_drop", rd_data0, exp0.pop_front());
    end
    if (rd_valid1) begin
      if (exp1.size() == 0) chk("rd_unexpected_wrap", rd_valid1, 0);
      else chk("rd_data_wrap", rd_data1, exp1.pop_front());
    end
  end

  initial begin
    clr(); reset = 1; arm = 1; step(); step();
    chk("rst_rd_valid", rd_valid0, 0);
    chk("rst_rd_data", rd_data0, 0);
    clr();

    // Basic session: three words, then end and drain.
    arm = 1; step(); clr();
    for (int i = 1; i <= 3; i++) begin wr_word(i, DATA_W'($urandom)); step(); end
    end_and_drain();
    chk("basic_done", done0, 1);

    // Twenty writes into a 16-deep buffer in both modes.
    arm = 1; step(); clr();
    for (int i = 1; i <= 20; i++) begin wr_word((i % 15) + 1, DATA_W'(i)); step(); end
    clr();
    chk("drop_fill16", fill0, 16);
    chk("drop_ovf4", ovf0, 4);
    chk("wrap_fill16", fill1, 16);
    chk("wrap_ovf4", ovf1, 4);
    end_and_drain();

    // Boundaries: empty write+read, full write+read, zero-count word, saturation.
    arm = 1; step(); clr();
    wr_word(5, DATA_W'($urandom)); rd_req = 1; step(); clr();
    chk("empty_wr_rd_valid", rd_valid0, 0);
    chk("empty_wr_rd_fill", fill0, 1);
    for (int i = 0; i < 15; i++) begin wr_word(2, DATA_W'($urandom)); step(); end
    wr_word(7, DATA_W'($urandom)); rd_req = 1; step(); clr();
    chk("full_wr_rd_fill", fill0, 16);
    chk("full_wr_rd_ovf", ovf0, 0);
    wr_word(0, DATA_W'($urandom)); step(); clr();
    chk("zero_cnt_ovf", ovf0, 0);
    for (int i = 0; i < 300; i++) begin wr_word(1, DATA_W'($urandom)); step(); end
    clr();
    chk("sat_ovf_drop", ovf0, 255);
    chk("sat_ovf_wrap", ovf1, 255);

    // Reset mid-capture at fill 7, with arm/write/read in the reset cycle.
    reset = 1; step(); clr();
    arm = 1; step(); clr();
    for (int i = 0; i < 7; i++) begin wr_word(3, DATA_W'($urandom)); step(); end
    clr();
    chk("pre_reset_fill7", fill0, 7);
    reset = 1; arm = 1; rd_req = 1; wr_word(4, DATA_W'($urandom)); step(); clr();
    chk("mid_reset_state", st0, 0);
    chk("mid_reset_fill", fill0, 0);
    chk("mid_reset_rd_valid", rd_valid0, 0);

    // Randomized sessions.
    for (int c = 0; c < 3000; c++) begin
      reset          = ($urandom_range(399) == 0);
      arm            = ($urandom_range(3) == 0);
      dct_valid      = ($urandom_range(3) != 0);
      dct_count      = CNT_W'($urandom_range(15));
      dct_buffer     = DATA_W'($urandom);
      test_ending    = ($urandom_range(39) == 0);
      test_has_ended = ($urandom_range(11) == 0);
      rd_req         = ($urandom_range(1) == 0);
      step();
    end
    clr(); step(); step();

    chk("leftover_drop", exp0.size(), 0);
    chk("leftover_wrap", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core7_oci_trace_capture.md
CORE7_OCI_TRACE_CAPTURE -- requirements
Module: core7_oci_trace_capture

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DATA_W, 30, trace word width.
- CNT_W, 4, trace count field width.
- DEPTH, 16, capture entries; power of two, >= 2.
- WRAP_MODE, 0, 0 = drop when full, 1 = overwrite oldest.

REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on its rising edge.
- reset, in, 1, synchronous, active-high reset.
- arm, in, 1, start capture session.
- dct_valid, in, 1, trace word qualifier.
- dct_buffer, in, DATA_W, trace word.
- dct_count, in, CNT_W, number of valid trace slots in word.
- test_ending, in, 1, end-of-test notice; stops capture.
- test_has_ended, in, 1, test finished.
- rd_req, in, 1, pop one entry.
- rd_data, out, CNT_W+DATA_W, popped entry {count, buffer}.
- rd_valid, out, 1, rd_data valid.
- fill_level, out, log2(DEPTH)+1, stored entries.
- overflow_cnt, out, 8, lost/overwritten entry count.
- state, out, 2, FSM state encoding.
- done, out, 1, high in DONE.

REQ-003 Clock/reset decided: one clock, clk; reset is synchronous and active-high, port reset.

Function
REQ-004 States, encoded on state: IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
REQ-005 IDLE->CAPTURE on arm; all other inputs ignored in IDLE; no reads, no writes.
REQ-006 CAPTURE->DRAIN on test_ending or test_has_ended.
REQ-007 DRAIN->DONE when test_has_ended=1 and registered fill_level=0 in the same cycle.
REQ-008 DONE->CAPTURE on arm; same edge clears pointers, fill_level, overflow_cnt.
REQ-009 Write qualifier: state=CAPTURE, dct_valid=1, dct_count!=0.
- Stores {dct_count, dct_buffer}.
- dct_count=0 words are discarded and not counted.
REQ-010 A qualifying write on the same cycle as test_ending is stored (last capture).
REQ-011 Read qualifier: rd_req=1, fill_level>0, state in {CAPTURE, DRAIN, DONE}; pops oldest entry.
REQ-012 rd_data/rd_valid are registered; one-cycle latency after the qualifying rd_req.
REQ-013 Unqualified rd_req: rd_valid=0 next cycle, rd_data holds its previous value.
REQ-014 Fill accounting: write only -> fill+1; read only -> fill-1; both -> fill unchanged.
REQ-015 Empty plus simultaneous write and read: write accepted, read ignored, fill becomes 1, rd_valid=0.
REQ-016 Full plus simultaneous write and read: both accepted in either mode; no overflow.
REQ-017 Full plus write without read, WRAP_MODE=0: word dropped; fill stays DEPTH; overflow_cnt+1.
REQ-018 Full plus write without read, WRAP_MODE=1: oldest entry overwritten; read pointer advances; fill stays DEPTH; overflow_cnt+1.
REQ-019 overflow_cnt saturates at 255; it never wraps.
REQ-020 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; fill_level reaches DEPTH exactly.
REQ-021 done=1 iff state=DONE.

Reset
REQ-022 reset=1 at a clk edge forces, regardless of other inputs:
- state=IDLE, pointers=0, fill_level=0, overflow_cnt=0.
- rd_valid=0, rd_data=0, done=0.
REQ-023 reset mid-session discards all stored entries; no rd_valid in the cycle after reset.
REQ-024 reset has priority over arm, writes and reads in the same cycle.

Verification
REQ-025 Directed scenarios the bench shall cover:
- Basic: arm, write 3 words (count=1,2,3), then test_ending, then test_has_ended while popping -> rd_data order count 1,2,3; DONE the cycle after fill_level reaches 0 with test_has_ended=1.
- Drop mode: DEPTH=16, WRAP_MODE=0, 20 writes without reads -> fill=16, overflow_cnt=4; pops return words 1..16.
- Wrap mode: WRAP_MODE=1, 20 writes -> fill=16, overflow_cnt=4; pops return words 5..20.
- Boundaries: full with simultaneous write+read -> fill stays 16, overflow unchanged. Empty with write+read -> fill=1, rd_valid=0. dct_count=0 write -> ignored.
- Saturation: 300 dropped writes -> overflow_cnt=255.
- Reset mid-capture at fill=7 -> next cycle: state=0, fill=0, rd_valid=0; an arm in the reset cycle is ignored.
